// File: rtl/uart_wrapper.sv
// UART front end that assembles two received bytes into a 16-bit command and sends single response bytes.
// Optional WAIT_LO timeout is enabled by defining UART_WRAPPER_TIMEOUT_EN.
module uart_wrapper #(
  parameter int BAUD_DIV     = 434,
  parameter int TIMEOUT_CLKS = 2_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic        TX,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp,
  input  logic        trmt,
  output logic        tx_done
);
  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] FULL = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF = CW'(BAUD_DIV / 2 - 1);

  if (BAUD_DIV < 4 || TIMEOUT_CLKS < 1) begin : g_bad_param
    $error("uart_wrapper: BAUD_DIV must be >= 4 and TIMEOUT_CLKS >= 1");
  end

  typedef enum logic {RX_IDLE, RX_BUSY} rx_st_t;
  typedef enum logic {TX_IDLE, TX_BUSY} tx_st_t;
  typedef enum logic {IDLE, WAIT_LO}    asm_st_t;

  // fill_q keeps the edge detector blind until real line samples reach rx_s2_q,
  // so a line held low across reset release never looks like a start bit.
  logic       rx_s1_q, rx_s2_q, rx_prev_q;
  logic [1:0] fill_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b0;
      fill_q    <= 2'b00;
    end else begin
      rx_s1_q   <= RX;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= fill_q[1] & rx_s2_q;
      fill_q    <= {fill_q[0], 1'b1};
    end
  end

  rx_st_t          rx_st_q, rx_st_d;
  logic [CW-1:0]   rx_cnt_q, rx_cnt_d;
  logic [3:0]      rx_bit_q, rx_bit_d;
  logic [7:0]      rx_sh_q, rx_sh_d;
  logic            rx_start, rx_accept;

  always_comb begin
    rx_st_d   = rx_st_q;
    rx_cnt_d  = rx_cnt_q;
    rx_bit_d  = rx_bit_q;
    rx_sh_d   = rx_sh_q;
    rx_start  = 1'b0;
    rx_accept = 1'b0;
    case (rx_st_q)
      RX_IDLE: if (rx_prev_q && !rx_s2_q) begin
        rx_st_d  = RX_BUSY;
        rx_cnt_d = '0;
        rx_bit_d = 4'd0;
        rx_start = 1'b1;
      end
      default: begin
        if (rx_cnt_q == ((rx_bit_q == 4'd0) ? HALF : FULL)) begin
          rx_cnt_d = '0;
          rx_bit_d = rx_bit_q + 4'd1;
          if (rx_bit_q == 4'd0) begin
            if (rx_s2_q) rx_st_d = RX_IDLE;
          end else if (rx_bit_q == 4'd9) begin
            rx_accept = 1'b1;
            rx_st_d   = RX_IDLE;
          end else begin
            rx_sh_d = {rx_s2_q, rx_sh_q[7:1]};
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
    endcase
  end

  asm_st_t     asm_st_q, asm_st_d;
  logic [15:0] cmd_q, cmd_d;
  logic        set_q, set_d, rdy_q, rdy_d;
  logic        tmo_hit;

`ifdef UART_WRAPPER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CLKS + 1);
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  assign tmo_cnt_d = (asm_st_q == WAIT_LO) ? tmo_cnt_q + 1'b1 : '0;
  assign tmo_hit   = (asm_st_q == WAIT_LO) && (tmo_cnt_q == TW'(TIMEOUT_CLKS - 1));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tmo_cnt_q <= '0;
    else        tmo_cnt_q <= tmo_cnt_d;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    asm_st_d = asm_st_q;
    cmd_d    = cmd_q;
    set_d    = 1'b0;
    case (asm_st_q)
      IDLE: if (rx_accept) begin
        cmd_d[15:8] = rx_sh_q;
        asm_st_d    = WAIT_LO;
      end
      default: begin
        if (rx_accept) begin
          cmd_d[7:0] = rx_sh_q;
          set_d      = 1'b1;
          asm_st_d   = IDLE;
        end else if (tmo_hit) begin
          asm_st_d = IDLE;
        end
      end
    endcase
    // set has priority over any clear arriving in the same clock
    rdy_d = set_q ? 1'b1 : (clr_cmd_rdy || rx_start) ? 1'b0 : rdy_q;
  end

  tx_st_t        tx_st_q, tx_st_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [3:0]    tx_bit_q, tx_bit_d;
  logic [8:0]    tx_sh_q, tx_sh_d;
  logic          tx_q, tx_d, done_q, done_d;

  always_comb begin
    tx_st_d  = tx_st_q;
    tx_cnt_d = tx_cnt_q;
    tx_bit_d = tx_bit_q;
    tx_sh_d  = tx_sh_q;
    tx_d     = tx_q;
    done_d   = done_q;
    case (tx_st_q)
      TX_IDLE: if (trmt) begin
        tx_st_d  = TX_BUSY;
        tx_cnt_d = '0;
        tx_bit_d = 4'd0;
        tx_sh_d  = {1'b1, resp};
        tx_d     = 1'b0;
        done_d   = 1'b0;
      end
      default: begin
        if (tx_cnt_q == FULL) begin
          tx_cnt_d = '0;
          if (tx_bit_q == 4'd9) begin
            tx_st_d = TX_IDLE;
            tx_d    = 1'b1;
            done_d  = 1'b1;
          end else begin
            tx_bit_d = tx_bit_q + 4'd1;
            tx_d     = tx_sh_q[0];
            tx_sh_d  = {1'b1, tx_sh_q[8:1]};
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_st_q  <= RX_IDLE;
      rx_cnt_q <= '0;
      rx_bit_q <= '0;
      rx_sh_q  <= '0;
      asm_st_q <= IDLE;
      cmd_q    <= '0;
      set_q    <= 1'b0;
      rdy_q    <= 1'b0;
      tx_st_q  <= TX_IDLE;
      tx_cnt_q <= '0;
      tx_bit_q <= '0;
      tx_sh_q  <= '1;
      tx_q     <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      rx_st_q  <= rx_st_d;
      rx_cnt_q <= rx_cnt_d;
      rx_bit_q <= rx_bit_d;
      rx_sh_q  <= rx_sh_d;
      asm_st_q <= asm_st_d;
      cmd_q    <= cmd_d;
      set_q    <= set_d;
      rdy_q    <= rdy_d;
      tx_st_q  <= tx_st_d;
      tx_cnt_q <= tx_cnt_d;
      tx_bit_q <= tx_bit_d;
      tx_sh_q  <= tx_sh_d;
      tx_q     <= tx_d;
      done_q   <= done_d;
    end
  end

  assign TX      = tx_q;
  assign cmd     = cmd_q;
  assign cmd_rdy = rdy_q;
  assign tx_done = done_q;
endmodule

// File: tb/tb_uart_wrapper.sv
// Randomized bench for uart_wrapper: serial command bytes in, response bytes out, checked against a frame-level model.
module tb_uart_wrapper;
  localparam int B   = 434;
  localparam int TMO = 10000;

  logic        clk = 1'b0, rst_n = 1'b0, RX = 1'b1, clr_cmd_rdy = 1'b0, trmt = 1'b0;
  logic [7:0]  resp = 8'h00;
  logic        TX, cmd_rdy, tx_done;
  logic [15:0] cmd;
  bit          go = 1'b0, tx_stop = 1'b0;
  int          checks = 0, errors = 0;

  always #5 clk = ~clk;

  uart_wrapper #(.BAUD_DIV(B), .TIMEOUT_CLKS(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .RX(RX), .TX(TX), .cmd(cmd), .cmd_rdy(cmd_rdy),
    .clr_cmd_rdy(clr_cmd_rdy), .resp(resp), .trmt(trmt), .tx_done(tx_done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transmit model: a frame is 10 bits of B clocks each, counted from the accepting edge.
  bit         m_busy = 1'b0, m_done = 1'b0;
  int         m_k = 0;
  logic [9:0] m_frame = 10'h3ff;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_k    <= 0;
    end else if (m_busy) begin
      if (m_k + 1 == 10 * B) begin
        m_busy <= 1'b0;
        m_done <= 1'b1;
      end else m_k <= m_k + 1;
    end else if (trmt) begin
      m_busy  <= 1'b1;
      m_k     <= 0;
      m_frame <= {1'b1, resp, 1'b0};
      m_done  <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (go) begin
      chk("tx_line", 32'(TX), 32'(m_busy ? m_frame[m_k / B] : 1'b1));
      chk("tx_done", 32'(tx_done), 32'(m_done));
    end
  end

  // Command model: bytes alternate high/low; the low byte raises cmd_rdy, any start bit drops it.
  logic [15:0] m_cmd = 16'h0000;
  bit          m_hi = 1'b0, m_rdy = 1'b0;

  task automatic send_byte(input logic [7:0] b);
    logic [9:0] f;
    f = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      RX = f[i];
      for (int c = 0; c < B; c++) begin
        if (i == 0 && c == 8) chk("rdy_clr_on_start", 32'(cmd_rdy), 32'd0);
        @(negedge clk);
      end
    end
    m_rdy = 1'b0;
    if (!m_hi) begin
      m_cmd[15:8] = b;
      m_hi = 1'b1;
    end else begin
      m_cmd[7:0] = b;
      m_hi = 1'b0;
      m_rdy = 1'b1;
    end
    chk("cmd_after_byte", 32'(cmd), 32'(m_cmd));
    chk("rdy_after_byte", 32'(cmd_rdy), 32'(m_rdy));
  endtask

  task automatic clear_rdy();
    clr_cmd_rdy = 1'b1;
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
    m_rdy = 1'b0;
    chk("rdy_after_clr", 32'(cmd_rdy), 32'd0);
    chk("cmd_after_clr", 32'(cmd), 32'(m_cmd));
  endtask

  // Transmit stimulus: one directed 8'hA5 frame, then random trmt pulses until told to stop.
  initial begin
    logic [9:0] wave;
    wave = 10'b11_0100_1010;
    wait (go);
    @(negedge clk);
    resp = 8'hA5;
    trmt = 1'b1;
    @(negedge clk);
    trmt = 1'b0;
    for (int c = 0; c <= 10 * B; c++) begin
      if (c < 10 * B && c % B == B / 2) chk("a5_wave", 32'(TX), 32'(wave[c / B]));
      if (c == 10 * B - 1) chk("a5_done_early", 32'(tx_done), 32'd0);
      if (c == 10 * B) chk("a5_done", 32'(tx_done), 32'd1);
      if (c == 4 * B + 3) begin
        resp = 8'h00;
        trmt = 1'b1;
      end
      if (c == 4 * B + 4) trmt = 1'b0;
      if (c < 10 * B) @(negedge clk);
    end
    while (!tx_stop) begin
      repeat ($urandom_range(0, 3000)) @(negedge clk);
      resp = 8'($urandom);
      trmt = 1'b1;
      @(negedge clk);
      trmt = 1'b0;
    end
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("rst_cmd", 32'(cmd), 32'h0000);
    chk("rst_rdy", 32'(cmd_rdy), 32'd0);
    chk("rst_tx", 32'(TX), 32'd1);
    chk("rst_done", 32'(tx_done), 32'd0);
    rst_n = 1'b1;
    go = 1'b1;
    repeat (10) @(negedge clk);

    send_byte(8'h47);
    send_byte(8'hF3);
    chk("cmd_47f3", 32'(cmd), 32'h47F3);
    chk("rdy_47f3", 32'(cmd_rdy), 32'd1);
    clear_rdy();

    RX = 1'b0;
    @(negedge clk);
    RX = 1'b1;
    repeat (600) @(negedge clk);
    chk("glitch_cmd", 32'(cmd), 32'(m_cmd));
    chk("glitch_rdy", 32'(cmd_rdy), 32'd0);

    for (int p = 0; p < 3; p++) begin
      for (int j = 0; j < 2; j++) begin
        repeat ($urandom_range(0, 40)) @(negedge clk);
        send_byte(8'($urandom));
      end
      if ($urandom_range(0, 1) == 1) clear_rdy();
    end

    send_byte(8'h2B);
    n = 0;
    while (!(m_busy && m_k > B) && n < 8000) begin
      @(negedge clk);
      n++;
    end
    chk("tx_busy_before_rst", 32'(n < 8000), 32'd1);
    RX = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("tx_async_rst", 32'(TX), 32'd1);
    chk("cmd_async_rst", 32'(cmd), 32'h0000);
    chk("rdy_async_rst", 32'(cmd_rdy), 32'd0);
    m_cmd = 16'h0000;
    m_hi  = 1'b0;
    m_rdy = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    RX = 1'b1;
    repeat (30) @(negedge clk);
    send_byte(8'h12);
    send_byte(8'h34);
    chk("cmd_1234_after_rst", 32'(cmd), 32'h1234);
    chk("rdy_1234_after_rst", 32'(cmd_rdy), 32'd1);

`ifdef UART_WRAPPER_TIMEOUT_EN
    send_byte(8'h47);
    repeat (12000) @(negedge clk);
    if (12000 > TMO) m_hi = 1'b0;
    send_byte(8'h12);
    send_byte(8'h34);
    chk("tmo_cmd_1234", 32'(cmd), 32'h1234);
    chk("tmo_rdy", 32'(cmd_rdy), 32'd1);
`endif

    tx_stop = 1'b1;
    n = 0;
    while (m_busy && n < 6000) begin
      @(negedge clk);
      n++;
    end
    chk("tx_idle_end", 32'(TX), 32'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_wrapper.md
UART_WRAPPER -- requirements
Module: uart_wrapper

Interface
REQ-001 Parameter BAUD_DIV, default 434, clocks per bit (50 MHz / 115200 baud).
REQ-002 Parameter TIMEOUT_CLKS, default 2_000_000, maximum clocks allowed between the high and low command bytes (used only under REQ-028).
REQ-003 Port clk  input  1  system clock; all logic is on its rising edge.
REQ-004 Port rst_n  input  1  asynchronous active-low reset.
REQ-005 Port RX  input  1  serial input from the remote commander; asynchronous to clk.
REQ-006 Port TX  output  1  serial output to the remote commander.
REQ-007 Port cmd  output  16  last assembled command, high byte first.
REQ-008 Port cmd_rdy  output  1  a complete 16-bit command is valid on cmd.
REQ-009 Port clr_cmd_rdy  input  1  consumer has taken cmd; clears cmd_rdy.
REQ-010 Port resp  input  8  response byte to transmit.
REQ-011 Port trmt  input  1  one-clock pulse that starts transmission of resp.
REQ-012 Port tx_done  output  1  the last response byte has been fully sent.

Function
REQ-013 RX shall pass through a two-flop synchronizer preset to 1; all receive logic uses the synchronized value only.
REQ-014 Receiver: a 1-to-0 transition on synchronized RX while idle starts a frame; the first sample is taken BAUD_DIV/2 clocks later, then one sample every BAUD_DIV clocks: start, 8 data bits LSB first, stop.
REQ-015 If the start-bit sample reads 1, the frame shall be discarded and the receiver returns to idle.
REQ-016 A byte is accepted at the stop-bit sample whatever the stop-bit value; a framing error is not reported.
REQ-017 Assembly FSM states: IDLE, WAIT_LO.
REQ-018 In IDLE, an accepted byte is written to cmd[15:8] and the FSM moves to WAIT_LO.
REQ-019 In WAIT_LO, an accepted byte is written to cmd[7:0], cmd_rdy is set on the next clock, and the FSM returns to IDLE.
REQ-020 cmd_rdy shall clear on clr_cmd_rdy, or when a new start bit is detected; if set and clear occur in the same clock, set wins.
REQ-021 cmd shall hold its value until it is overwritten by REQ-018 or REQ-019; there is no byte-level back-pressure.
REQ-022 Transmitter: trmt while idle loads resp and sends start (0), 8 data bits LSB first, and stop (1), each bit BAUD_DIV clocks long; TX is 1 when idle.
REQ-023 tx_done shall clear on an accepted trmt and set at the end of the stop-bit period; trmt while transmitting is ignored.
REQ-024 Receiver and transmitter operate independently and may be active at the same time.

Reset
REQ-025 On rst_n low: cmd=16'h0000, cmd_rdy=0, tx_done=0, TX=1, FSM=IDLE, all counters 0, synchronizer flops=1.
REQ-026 Reset mid-frame shall abort both directions immediately; a partially received byte is lost, and TX returns to 1 asynchronously.
REQ-027 After reset release, the receiver requires a fresh falling edge; a line that was already low is not treated as a start bit.

Configuration
REQ-028 With macro UART_WRAPPER_TIMEOUT_EN defined: in WAIT_LO, a counter cleared on entry counts clocks; at TIMEOUT_CLKS the FSM returns to IDLE, cmd[15:8] is not restored, and cmd_rdy is not set.
REQ-029 Without UART_WRAPPER_TIMEOUT_EN: WAIT_LO waits indefinitely, and no timeout counter is synthesized.

Verification
REQ-030 Serial bytes 8'h47 then 8'hF3 at BAUD_DIV=434 -> cmd=16'h47F3, cmd_rdy=1 within 2 clocks of the second stop-bit sample.
REQ-031 cmd_rdy=1, then clr_cmd_rdy pulse -> cmd_rdy=0 next clock, cmd unchanged; new start bit with no clear -> cmd_rdy=0.
REQ-032 resp=8'hA5, trmt pulse -> TX waveform 0,1,0,1,0,0,1,0,1,1 at 434 clocks per bit; tx_done=1 after 4340 clocks; a second trmt mid-frame has no effect.
REQ-033 1-clock RX glitch low (under 217 clocks) -> no byte accepted, FSM stays IDLE.
REQ-034 rst_n asserted after the high byte of 16'h2BCD -> FSM=IDLE; then full 16'h1234 -> cmd=16'h1234.
REQ-035 UART_WRAPPER_TIMEOUT_EN, TIMEOUT_CLKS=10000: byte 8'h47, 12000 idle clocks, bytes 8'h12, 8'h34 -> cmd=16'h1234, cmd_rdy=1.
